// File: rtl/cpu0_mem_arbiter_pkg.sv
// Shared types and constants for the CPU0 byte-memory arbiter.
// Requester indices, size encodings and the access sequencer states.
package cpu0_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    TAIL  = 2'd2,
    ACK   = 2'd3
  } state_e;

  localparam int unsigned NREQ = 3;

  localparam logic [1:0] REQ_DATA  = 2'd0;
  localparam logic [1:0] REQ_FETCH = 2'd1;
  localparam logic [1:0] REQ_AUX   = 2'd2;

  localparam logic SZ_BYTE = 1'b0;
  localparam logic SZ_WORD = 1'b1;

  function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
    logic [1:0] idx;
    idx = REQ_DATA;
    if (oh[1]) idx = REQ_FETCH;
    if (oh[2]) idx = REQ_AUX;
    return idx;
  endfunction

endpackage

// File: rtl/cpu0_mem_arbiter_if.sv
// Requester-side bus of the CPU0 memory arbiter: per-requester request
// fields in, shared completion/read data and ownership out.
interface cpu0_mem_arbiter_if #(
  parameter int AW = 32
);
  logic [2:0]      req;
  logic [2:0]      we;
  logic [2:0]      size;
  logic [3*AW-1:0] addr;
  logic [95:0]     wdata;
  logic [2:0]      ack;
  logic            err;
  logic [31:0]     rdata;
  logic [2:0]      grant;
  logic            busy;

  modport master (
    output req, we, size, addr, wdata,
    input  ack, err, rdata, grant, busy
  );

  modport slave (
    input  req, we, size, addr, wdata,
    output ack, err, rdata, grant, busy
  );
endinterface

// File: rtl/cpu0_mem_arbiter_rr.sv
// Three-way round-robin picker: the first requesting index after the last
// granted one, in cyclic order 0 -> 1 -> 2 -> 0. Purely combinational.
module cpu0_rr_arbiter (
  input  logic [2:0] req_i,
  input  logic [1:0] last_i,
  output logic [2:0] win_o
);

  always_comb begin
    win_o = 3'b000;
    case (last_i)
      2'd0: begin
        if      (req_i[1]) win_o = 3'b010;
        else if (req_i[2]) win_o = 3'b100;
        else if (req_i[0]) win_o = 3'b001;
      end
      2'd1: begin
        if      (req_i[2]) win_o = 3'b100;
        else if (req_i[0]) win_o = 3'b001;
        else if (req_i[1]) win_o = 3'b010;
      end
      default: begin
        if      (req_i[0]) win_o = 3'b001;
        else if (req_i[1]) win_o = 3'b010;
        else if (req_i[2]) win_o = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/cpu0_mem_arbiter.sv
// Shares one byte-wide synchronous RAM among the CPU0 data, fetch and aux
// requesters, serialising each granted access into big-endian byte cycles.
//
// state | meaning
// IDLE  | no owner; sample req and latch the round-robin winner
// ISSUE | one memory byte cycle per clock, cnt selects the byte
// TAIL  | read only: capture the last byte returned by the RAM
// ACK   | one-cycle ack to the owner with rdata/err valid
module cpu0_mem_arbiter
  import cpu0_mem_pkg::*;
#(
  parameter int AW  = 32,
  parameter int MAW = 8
) (
  input  logic                clock,
  input  logic                reset,
  cpu0_mem_arbiter_if.slave   bus,
  output logic                mem_en,
  output logic                mem_we,
  output logic [MAW-1:0]      mem_addr,
  output logic [7:0]          mem_wdata,
  input  logic [7:0]          mem_rdata
);

  state_e          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [2:0]      gnt_q, gnt_d;
  logic            we_q, we_d;
  logic            size_q, size_d;
  logic [MAW-1:0]  base_q, base_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            cap_q, cap_d;
  logic [1:0]      lane_q, lane_d;

  logic [2:0]      win;
  logic [1:0]      win_idx;
  logic            sel_we;
  logic            sel_size;
  logic [MAW-1:0]  sel_addr;
  logic [31:0]     sel_wdata;
  logic            last_issue;
  logic [31:0]     wdata_sh;
  logic [4:0]      lane_sh;
  logic            unused_addr;

  cpu0_rr_arbiter u_rr (
    .req_i  (bus.req),
    .last_i (ptr_q),
    .win_o  (win)
  );

  assign win_idx = onehot_to_idx(win);

  // Address bits above MAW never reach the RAM; accesses wrap modulo 2^MAW.
  assign unused_addr = ^bus.addr;

  always_comb begin
    sel_we    = bus.we[win_idx];
    sel_size  = bus.size[win_idx];
    sel_addr  = bus.addr[0 +: MAW];
    sel_wdata = bus.wdata[0 +: 32];
    case (win_idx)
      REQ_FETCH: begin
        sel_addr  = bus.addr[AW +: MAW];
        sel_wdata = bus.wdata[32 +: 32];
      end
      REQ_AUX: begin
        sel_addr  = bus.addr[2*AW +: MAW];
        sel_wdata = bus.wdata[64 +: 32];
      end
      default: ;
    endcase
  end

  assign last_issue = (size_q == SZ_WORD) ? (cnt_q == 2'd3) : 1'b1;
  // Big-endian: byte cnt of a word is lane 3-cnt, i.e. bits [31-8*cnt -: 8].
  assign wdata_sh   = wdata_q >> {~cnt_q, 3'b000};
  assign lane_sh    = {lane_q, 3'b000};

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    we_d      = we_q;
    size_d    = size_q;
    base_d    = base_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    cap_d     = 1'b0;
    lane_d    = lane_q;
    rdata_d   = rdata_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 8'h00;

    if (cap_q) begin
      rdata_d = (rdata_q & ~(32'h0000_00FF << lane_sh)) |
                ({24'h0, mem_rdata} << lane_sh);
    end

    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          gnt_d   = win;
          we_d    = sel_we;
          size_d  = sel_size;
          base_d  = sel_addr;
          wdata_d = sel_wdata;
          cnt_d   = 2'd0;
          rdata_d = 32'h0;
          err_d   = (sel_size == SZ_WORD) && (sel_addr[1:0] != 2'b00);
          state_d = ((sel_size == SZ_WORD) && (sel_addr[1:0] != 2'b00)) ? ACK : ISSUE;
        end
      end
      ISSUE: begin
        mem_en   = 1'b1;
        mem_we   = we_q;
        mem_addr = base_q + MAW'(cnt_q);
        if (we_q) begin
          mem_wdata = (size_q == SZ_WORD) ? wdata_sh[7:0] : wdata_q[7:0];
        end
        cap_d  = ~we_q;
        lane_d = (size_q == SZ_WORD) ? ~cnt_q : 2'd0;
        cnt_d  = cnt_q + 2'd1;
        if (last_issue) begin
          state_d = we_q ? ACK : TAIL;
        end
      end
      TAIL: begin
        state_d = ACK;
      end
      ACK: begin
        ptr_d   = onehot_to_idx(gnt_q);
        gnt_d   = 3'b000;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= REQ_AUX;
      gnt_q   <= 3'b000;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      base_q  <= '0;
      wdata_q <= 32'h0;
      cnt_q   <= 2'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
      cap_q   <= 1'b0;
      lane_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cap_q   <= cap_d;
      lane_q  <= lane_d;
    end
  end

  assign bus.ack   = (state_q == ACK) ? gnt_q : 3'b000;
  assign bus.err   = (state_q == ACK) & err_q;
  assign bus.rdata = (state_q == ACK) ? rdata_q : 32'h0;
  assign bus.grant = gnt_q;
  assign bus.busy  = |gnt_q;

endmodule

// File: tb/tb_cpu0_mem_arbiter.sv
// Directed and randomized bench for cpu0_mem_arbiter with a behavioural
// byte-memory reference model and a synchronous RAM attached.
module tb_cpu0_mem_arbiter;
  localparam int AW  = 32;
  localparam int MAW = 8;

  logic           clock = 1'b0;
  logic           reset;
  logic           mem_en, mem_we;
  logic [MAW-1:0] mem_addr;
  logic [7:0]     mem_wdata;
  logic [7:0]     mem_rdata;

  logic           pl_en = 1'b0;
  logic [7:0]     pl_addr = 8'h00;
  logic [7:0]     pl_data = 8'h00;

  logic [7:0]     ram [256];
  logic [7:0]     ref_mem [256];

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  cpu0_mem_arbiter_if #(.AW(AW)) bus ();

  cpu0_mem_arbiter #(.AW(AW), .MAW(MAW)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always @(posedge clock) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    @(negedge clock);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    ref_mem[a] = d;
    @(posedge clock);
    #1 pl_en = 1'b0;
  endtask

  task automatic set_fields(input int r, input bit w, input bit sz,
                            input logic [31:0] a, input logic [31:0] d);
    bus.we[r]              = w;
    bus.size[r]            = sz;
    bus.addr[r*AW +: AW]   = a;
    bus.wdata[r*32 +: 32]  = d;
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Single access from one requester, checked against the byte-memory model.
  task automatic run_access(input int r, input bit w, input bit sz,
                            input logic [31:0] a, input logic [31:0] d, input string tag);
    logic [7:0] ea[$];
    logic [7:0] ed[$];
    logic [7:0] oa[$];
    logic [7:0] od[$];
    logic       ow[$];
    bit         mis;
    int         nb, elat, lat, t;
    logic [31:0] erd;
    logic [7:0]  b;

    mis  = sz && (a[1:0] != 2'b00);
    nb   = mis ? 0 : (sz ? 4 : 1);
    elat = mis ? 0 : (sz ? (w ? 4 : 5) : (w ? 1 : 2));
    erd  = 32'h0;
    for (int i = 0; i < nb; i++) begin
      b = a[7:0] + 8'(i);
      ea.push_back(b);
      if (w) begin
        ed.push_back(sz ? 8'(d >> (8 * (3 - i))) : d[7:0]);
        ref_mem[b] = sz ? 8'(d >> (8 * (3 - i))) : d[7:0];
      end else begin
        erd = {erd[23:0], ref_mem[b]};
      end
    end

    @(negedge clock);
    set_fields(r, w, sz, a, d);
    bus.req[r] = 1'b1;

    t = 0;
    do begin @(posedge clock); #1; t++; end while (bus.grant == 3'b000 && t < 50);
    chk({tag, " grant"}, 32'(bus.grant), 32'(1) << r);
    chk({tag, " busy"}, 32'(bus.busy), 32'h1);

    // Requester inputs may change once granted; the latched copy must be used.
    set_fields(r, ~w, ~sz, $urandom, $urandom);

    lat = 0;
    while (bus.ack == 3'b000 && lat < 20) begin
      if (mem_en) begin
        oa.push_back(mem_addr);
        od.push_back(mem_wdata);
        ow.push_back(mem_we);
      end
      @(posedge clock); #1; lat++;
    end
    bus.req[r] = 1'b0;

    chk({tag, " ack"}, 32'(bus.ack), 32'(1) << r);
    chk({tag, " latency"}, lat, elat);
    chk({tag, " err"}, 32'(bus.err), 32'(mis));
    if (!w && !mis) chk({tag, " rdata"}, bus.rdata, erd);
    chk({tag, " ncycles"}, oa.size(), nb);
    for (int i = 0; i < nb && i < oa.size(); i++) begin
      chk($sformatf("%s addr%0d", tag, i), 32'(oa[i]), 32'(ea[i]));
      chk($sformatf("%s we%0d", tag, i), 32'(ow[i]), 32'(w));
      if (w) chk($sformatf("%s wbyte%0d", tag, i), 32'(od[i]), 32'(ed[i]));
    end

    @(posedge clock); #1;
    chk({tag, " idle"}, {bus.grant, bus.busy}, 32'h0);
  endtask

  task automatic serve(input int exp_r, input logic [2:0] clr, input string tag);
    int t;
    t = 0;
    do begin @(posedge clock); #1; t++; end while (bus.grant == 3'b000 && t < 50);
    chk({tag, " grant"}, 32'(bus.grant), 32'(1) << exp_r);
    t = 0;
    while (bus.ack == 3'b000 && t < 50) begin @(posedge clock); #1; t++; end
    chk({tag, " ack"}, 32'(bus.ack), 32'(1) << exp_r);
    bus.req = bus.req & ~clr;
  endtask

  initial begin
    int t;
    bit w, sz;
    logic [31:0] a;

    reset     = 1'b1;
    bus.req   = 3'b000;
    bus.we    = 3'b000;
    bus.size  = 3'b000;
    bus.addr  = '0;
    bus.wdata = '0;
    #1;
    chk("reset bus outs", {bus.ack, bus.err, bus.grant, bus.busy}, 32'h0);
    chk("reset rdata", bus.rdata, 32'h0);
    chk("reset mem outs", {mem_en, mem_we, mem_addr, mem_wdata}, 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 256; i++) preload(8'(i), 8'($urandom));
    preload(8'h00, 8'h00);
    preload(8'h01, 8'h1F);
    preload(8'h02, 8'h00);
    preload(8'h03, 8'h18);

    run_access(1, 1'b0, 1'b1, 32'h0000_0000, 32'h0, "fetch word rd");
    chk("fetch word rd model", {ref_mem[0], ref_mem[1], ref_mem[2], ref_mem[3]}, 32'h001F_0018);

    run_access(0, 1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, "data word wr");
    run_access(0, 1'b0, 1'b0, 32'h0000_0021, 32'h0, "data byte rd");
    chk("byte rd model", {24'h0, ref_mem[8'h21]}, 32'h0000_0034);

    pulse_reset();
    @(negedge clock);
    for (int r = 0; r < 3; r++) set_fields(r, 1'b0, 1'b0, 32'h0, 32'h0);
    bus.req = 3'b111;
    serve(0, 3'b001, "rr3 first");
    serve(1, 3'b010, "rr3 second");
    serve(2, 3'b100, "rr3 third");
    @(negedge clock);
    bus.req = 3'b011;
    serve(0, 3'b000, "rr2 a");
    serve(1, 3'b000, "rr2 b");
    serve(0, 3'b000, "rr2 c");
    serve(1, 3'b011, "rr2 d");

    run_access(2, 1'b0, 1'b1, 32'h0000_0022, 32'h0, "aux misaligned");

    for (int i = 0; i < 4; i++) preload(8'h40 + 8'(i), 8'h11);
    run_access(0, 1'b0, 1'b0, 32'h0000_0003, 32'h0, "pre-abort rd");
    @(negedge clock);
    set_fields(0, 1'b1, 1'b1, 32'h0000_0040, 32'hAABB_CCDD);
    bus.req[0] = 1'b1;
    t = 0;
    do begin @(posedge clock); #1; t++; end while (bus.grant == 3'b000 && t < 50);
    chk("abort grant", 32'(bus.grant), 32'h1);
    repeat (2) begin @(posedge clock); #1; end
    chk("abort pre mem_en", 32'(mem_en), 32'h1);
    reset = 1'b1;
    #1;
    chk("abort mem_en", 32'(mem_en), 32'h0);
    chk("abort grant clr", {bus.grant, bus.busy}, 32'h0);
    bus.req = 3'b000;
    repeat (2) begin
      @(posedge clock); #1;
      chk("abort no ack", 32'(bus.ack), 32'h0);
    end
    @(negedge clock);
    reset = 1'b0;
    ref_mem[8'h40] = 8'hAA;
    ref_mem[8'h41] = 8'hBB;
    @(negedge clock);
    for (int r = 0; r < 3; r++) set_fields(r, 1'b0, 1'b0, 32'h0, 32'h0);
    bus.req = 3'b111;
    serve(0, 3'b111, "post-reset first");
    run_access(0, 1'b0, 1'b1, 32'h0000_0040, 32'h0, "abort readback");
    chk("abort readback model", {ref_mem[8'h40], ref_mem[8'h41], ref_mem[8'h42], ref_mem[8'h43]},
        32'hAABB_1111);

    run_access(0, 1'b1, 1'b0, 32'h1000_00FF, 32'h0000_005A, "byte wr wrap");
    run_access(1, 1'b0, 1'b0, 32'h0000_00FF, 32'h0, "byte rd wrap");

    for (int k = 0; k < 24; k++) begin
      w  = 1'($urandom_range(0, 1));
      sz = 1'($urandom_range(0, 1));
      a  = $urandom;
      if (sz && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      run_access(int'($urandom_range(0, 2)), w, sz, a, $urandom, $sformatf("rand%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu0_mem_arbiter.md
Name: cpu0_mem_arbiter

Overview:
- Shares one byte-wide synchronous program/data memory among three CPU0 requesters: 0 = data port (LD/ST/LDB/STB/PUSH/POP), 1 = instruction fetch, 2 = auxiliary (debug/loader).
- Arbitrates round-robin and serialises each granted access into 1 or 4 byte cycles.
- Words are big-endian: byte at addr goes to bits [31:24].
- Sits between the CPU0 core and the byte RAM, replacing direct array indexing by the core.

Parameters:
- AW, 32, requester address width.
- MAW, 8, memory address width; the memory holds 2^MAW bytes.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  3  per-requester request; held until the matching ack.
- we  in  3  per-requester write enable.
- size  in  3  per-requester size: 1 = word (4 bytes), 0 = byte.
- addr  in  3*AW  per-requester byte address; requester i uses [i*AW +: AW].
- wdata  in  96  per-requester write data; requester i uses [i*32 +: 32].
- ack  out  3  one-cycle completion pulse to the granted requester.
- err  out  1  misalignment error; valid only while ack is high.
- rdata  out  32  shared read data; valid only while ack is high.
- grant  out  3  one-hot current owner; zero when idle.
- busy  out  1  high from grant until ack inclusive.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write strobe.
- mem_addr  out  MAW  memory byte address.
- mem_wdata  out  8  memory write byte.
- mem_rdata  in  8  memory read byte; valid one cycle after an mem_en read.

Behaviour:
- Reset (async, active-high): state IDLE; ack=0, err=0, rdata=0, grant=0, busy=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Round-robin pointer is set so requester 0 has top priority.
- States: IDLE, ISSUE, TAIL, ACK.
- IDLE, at a rising edge with any req high:
  - Pick the winner: the first requester after the last granted one, cyclic order 0→1→2→0.
  - Latch its we, size, addr[MAW-1:0] and wdata. Set grant and busy. Clear byte counter cnt.
  - Word access with addr[1:0]≠0 goes straight to ACK with err=1 and issues no memory cycles.
  - Otherwise go to ISSUE.
- ISSUE: one byte per cycle.
  - mem_en=1, mem_we=latched we, mem_addr=base+cnt (MAW-bit wrap).
  - Write data: word writes drive mem_wdata=wdata[31-8*cnt -: 8]; byte writes drive wdata[7:0].
  - Reads: each mem_rdata byte is captured one cycle after its issue into the rdata lane for that byte.
  - Last issue is cnt=3 for word, cnt=0 for byte. After it, writes go to ACK and reads go to TAIL.
- TAIL: mem_en=0; capture the final read byte; go to ACK.
- ACK: ack[granted]=1 for exactly one cycle, with rdata and err valid.
  - Byte reads are zero-extended: rdata = {24'b0, byte}.
  - Update the round-robin pointer; clear grant and busy on the exit edge; go to IDLE.
- Latency, counted from the grant edge to the ack cycle:
  - word write 4 cycles, word read 5 cycles;
  - byte write 1 cycle, byte read 2 cycles;
  - misaligned word 0 cycles (ack in the cycle immediately after grant).
- Back-to-back requests: IDLE always lasts at least one cycle, so a requester that drops req on the edge ending ack is never granted twice.
- req changes on non-granted requesters mid-access are ignored until IDLE.
- Requester inputs may change after grant; the latched copies are used.
- Reset asserted mid-access:
  - Access aborts immediately and mem_en drops asynchronously.
  - No ack is issued.
  - Bytes already written remain in memory.
- Address bits above MAW are ignored; addresses wrap modulo 2^MAW.

Decomposition:
- Package cpu0_mem_pkg:
  - state enum {IDLE, ISSUE, TAIL, ACK};
  - requester indices REQ_DATA=0, REQ_FETCH=1, REQ_AUX=2;
  - size encodings SZ_BYTE=0, SZ_WORD=1.
- Sub-module cpu0_rr_arbiter: 3-way round-robin picker.
  - Inputs: req vector and last-grant pointer.
  - Output: one-hot winner (combinational).

Test Plan:
- Preload bytes 0x00..0x03 = 00,1F,00,18; requester 1 word read at addr 0 → mem_addr sequence 0,1,2,3; ack[1] at grant+5 with rdata=0x001F0018; err=0.
- Requester 0 word write 0x12345678 to 0x20 → mem_wdata 12,34,56,78 at addresses 0x20..0x23; ack[0] at grant+4. Then a byte read at 0x21 → rdata=0x00000034, ack at grant+2.
- All three req high together after reset → grants in order 0,1,2. Then requesters 0 and 1 held high → grants alternate 0,1,0,1 with no back-to-back double grant.
- Requester 2 word read at 0x22 → ack[2] and err=1 in the cycle after grant; mem_en never asserted.
- Reset asserted after 2 byte cycles of a word write of 0xAABBCCDD to 0x40 → mem_en low at once; only 0x40=AA and 0x41=BB written; no ack. After reset release, a request from requester 0 is granted first.
- Byte write 0x5A to addr 0x1_00000FF with MAW=8 → mem_addr=0xFF; ack at grant+1.
